// File: rtl/wb_board_io.sv
// Wishbone board I/O: synchronised switches/buttons, W1C edge pending bits, interrupt masks and an LED register.
// Define BOARD_DEBOUNCE_EN to include the per-input debounce counters; otherwise deb follows the synchroniser.
module wb_board_io #(
    parameter int DEV_ADDR_BITS   = 8,
    parameter int SW_NUM          = 8,
    parameter int BTN_NUM         = 5,
    parameter int LED_NUM         = 8,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SW_NUM-1:0]        switch,
    input  logic [BTN_NUM-1:0]       btn,
    output logic [LED_NUM-1:0]       led,
    input  logic                     wbs_cs_i,
    input  logic [DEV_ADDR_BITS-3:0] wbs_addr_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_data_i,
    input  logic                     wbs_we_i,
    output logic [31:0]              wbs_data_o,
    output logic                     wbs_ack_o,
    output logic                     interrupt
);
    localparam int N  = SW_NUM + BTN_NUM;
    localparam int AW = DEV_ADDR_BITS - 2;

    localparam logic [AW-1:0] A_SW       = AW'(0);
    localparam logic [AW-1:0] A_BTN      = AW'(1);
    localparam logic [AW-1:0] A_PEND_SW  = AW'(2);
    localparam logic [AW-1:0] A_PEND_BTN = AW'(3);
    localparam logic [AW-1:0] A_LED      = AW'(4);
    localparam logic [AW-1:0] A_MASK_SW  = AW'(5);
    localparam logic [AW-1:0] A_MASK_BTN = AW'(6);
    localparam logic [AW-1:0] A_EDGE     = AW'(7);

    if (DEBOUNCE_CYCLES < 2 || SW_NUM < 1 || SW_NUM > 32 || BTN_NUM < 1 || BTN_NUM > 32 ||
        LED_NUM < 1 || LED_NUM > 32) begin : g_param_check
        $error("wb_board_io: parameter out of range");
    end

    // Switches occupy [SW_NUM-1:0], buttons the bits above them.
    logic [N-1:0]       meta_q, sync_q, deb_q, deb_d, evt;
    logic [SW_NUM-1:0]  pend_sw_q, pend_sw_d, mask_sw_q, mask_sw_d;
    logic [BTN_NUM-1:0] pend_btn_q, pend_btn_d, mask_btn_q, mask_btn_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic [1:0]         edge_sw_q, edge_sw_d, edge_btn_q, edge_btn_d;
    logic [31:0]        lane_mask, wbits, rdata, data_q;
    logic               ack_q, irq_q, accept, wr;

    assign accept = wbs_cs_i & ~ack_q;
    assign wr     = accept & wbs_we_i;

    always_comb begin
        for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{wbs_sel_i[i]}};
    end
    assign wbits = wbs_data_i & lane_mask;

    logic unused_bits;
    assign unused_bits = ^{lane_mask, wbits};

`ifdef BOARD_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    logic [N-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) deb_d[i] = sync_q[i];
                else                                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign deb_d = sync_q;
`endif

    function automatic logic edge_hit(input logic prev, input logic curr, input logic [1:0] mode);
        case (mode)
            2'b00:   edge_hit = prev ^ curr;
            2'b01:   edge_hit = ~prev & curr;
            2'b10:   edge_hit = prev & ~curr;
            default: edge_hit = 1'b0;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++)
            evt[i] = edge_hit(deb_q[i], deb_d[i], (i < SW_NUM) ? edge_sw_q : edge_btn_q);
    end

    // Read data is the pre-write value; the ack edge captures it together with any write.
    always_comb begin
        rdata = '0;
        case (wbs_addr_i)
            A_SW:       rdata = 32'(deb_q[SW_NUM-1:0]);
            A_BTN:      rdata = 32'(deb_q[N-1:SW_NUM]);
            A_PEND_SW:  rdata = 32'(pend_sw_q);
            A_PEND_BTN: rdata = 32'(pend_btn_q);
            A_LED:      rdata = 32'(led_q);
            A_MASK_SW:  rdata = 32'(mask_sw_q);
            A_MASK_BTN: rdata = 32'(mask_btn_q);
            A_EDGE:     rdata = {22'd0, edge_btn_q, 6'd0, edge_sw_q};
            default:    rdata = '0;
        endcase
    end

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        pend_sw_d  = pend_sw_q;
        pend_btn_d = pend_btn_q;
        led_d      = led_q;
        mask_sw_d  = mask_sw_q;
        mask_btn_d = mask_btn_q;
        edge_sw_d  = edge_sw_q;
        edge_btn_d = edge_btn_q;
        if (wr) begin
            case (wbs_addr_i)
                A_PEND_SW:  pend_sw_d  = pend_sw_q & ~wbits[SW_NUM-1:0];
                A_PEND_BTN: pend_btn_d = pend_btn_q & ~wbits[BTN_NUM-1:0];
                A_LED:      led_d      = (led_q & ~lane_mask[LED_NUM-1:0]) | wbits[LED_NUM-1:0];
                A_MASK_SW:  mask_sw_d  = (mask_sw_q & ~lane_mask[SW_NUM-1:0]) | wbits[SW_NUM-1:0];
                A_MASK_BTN: mask_btn_d = (mask_btn_q & ~lane_mask[BTN_NUM-1:0]) | wbits[BTN_NUM-1:0];
                A_EDGE: begin
                    edge_sw_d  = (edge_sw_q & ~lane_mask[1:0]) | wbits[1:0];
                    edge_btn_d = (edge_btn_q & ~lane_mask[9:8]) | wbits[9:8];
                end
                default: ;
            endcase
        end
        // A new edge event overrides a simultaneous W1C of the same bit.
        pend_sw_d  = pend_sw_d | evt[SW_NUM-1:0];
        pend_btn_d = pend_btn_d | evt[N-1:SW_NUM];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            deb_q      <= '0;
            pend_sw_q  <= '0;
            pend_btn_q <= '0;
            mask_sw_q  <= '0;
            mask_btn_q <= '0;
            led_q      <= '0;
            edge_sw_q  <= '0;
            edge_btn_q <= '0;
            ack_q      <= 1'b0;
            data_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            meta_q     <= {btn, switch};
            sync_q     <= meta_q;
            deb_q      <= deb_d;
            pend_sw_q  <= pend_sw_d;
            pend_btn_q <= pend_btn_d;
            mask_sw_q  <= mask_sw_d;
            mask_btn_q <= mask_btn_d;
            led_q      <= led_d;
            edge_sw_q  <= edge_sw_d;
            edge_btn_q <= edge_btn_d;
            ack_q      <= accept;
            data_q     <= accept ? rdata : '0;
            irq_q      <= (|(pend_sw_q & mask_sw_q)) | (|(pend_btn_q & mask_btn_q));
        end
    end

    assign led        = led_q;
    assign wbs_ack_o  = ack_q;
    assign wbs_data_o = data_q;
    assign interrupt  = irq_q;
endmodule

// File: tb/tb_wb_board_io.sv
// Randomised and directed bench for wb_board_io against a behavioural model of the register map.
// Works with or without BOARD_DEBOUNCE_EN; expectations follow the selected build.
`timescale 1ns/1ps
module tb_wb_board_io;
    localparam int SW_N = 8, BTN_N = 5, LED_N = 8, DEB = 16, AB = 8;
    localparam int NIN = SW_N + BTN_N;
    localparam bit [31:0] SW_MSK  = (32'd1 << SW_N) - 1;
    localparam bit [31:0] BTN_MSK = (32'd1 << BTN_N) - 1;
    localparam bit [31:0] LED_MSK = (32'd1 << LED_N) - 1;
`ifdef BOARD_DEBOUNCE_EN
    localparam int DEB_LAT = 2 + DEB;
    localparam bit [31:0] GLITCH_PEND = 32'h00, PULSE_BTN = 32'h0, PULSE_PEND = 32'h0;
`else
    localparam int DEB_LAT = 3;
    localparam bit [31:0] GLITCH_PEND = 32'h08, PULSE_BTN = 32'h1, PULSE_PEND = 32'h1;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [SW_N-1:0]  switch;
    logic [BTN_N-1:0] btn;
    logic [LED_N-1:0] led;
    logic             cs, we, ack, irq;
    logic [AB-3:0]    addr;
    logic [3:0]       sel;
    logic [31:0]      wdata, rdata;
    int checks = 0, errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    wb_board_io #(.DEV_ADDR_BITS(AB), .SW_NUM(SW_N), .BTN_NUM(BTN_N), .LED_NUM(LED_N),
                  .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .switch(switch), .btn(btn), .led(led),
        .wbs_cs_i(cs), .wbs_addr_i(addr), .wbs_sel_i(sel), .wbs_data_i(wdata), .wbs_we_i(we),
        .wbs_data_o(rdata), .wbs_ack_o(ack), .interrupt(irq));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [NIN-1:0] m_h1, m_h2, m_deb;
    int           m_run [NIN];
    bit [31:0]    m_pend_sw, m_pend_btn, m_led, m_mask_sw, m_mask_btn, m_edge, m_data;
    bit           m_ack, m_irq;

    function automatic bit [31:0] m_read(input int a);
        case (a)
            0: return 32'(m_deb[SW_N-1:0]);
            1: return 32'(m_deb[NIN-1:SW_N]);
            2: return m_pend_sw;
            3: return m_pend_btn;
            4: return m_led;
            5: return m_mask_sw;
            6: return m_mask_btn;
            7: return m_edge;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_event(input bit was, input bit is, input bit [1:0] mode);
        if (was == is) return 1'b0;
        case (mode)
            2'd0: return 1'b1;
            2'd1: return is;
            2'd2: return !is;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit [NIN-1:0] sv, nd;
        bit [31:0] bm, wd, rd, ev_sw, ev_btn;
        bit acc, irq_n;
        int a;
        if (rst) begin
            m_h1 = '0; m_h2 = '0; m_deb = '0;
            foreach (m_run[i]) m_run[i] = 0;
            m_pend_sw = 0; m_pend_btn = 0; m_led = 0; m_mask_sw = 0; m_mask_btn = 0; m_edge = 0;
            m_ack = 0; m_data = 0; m_irq = 0;
        end else begin
            a     = int'(addr);
            acc   = cs && !m_ack;
            rd    = m_read(a);
            irq_n = ((m_pend_sw & m_mask_sw) != 0) || ((m_pend_btn & m_mask_btn) != 0);
            sv = m_h2; m_h2 = m_h1; m_h1 = {btn, switch};
            nd = m_deb;
            for (int i = 0; i < NIN; i++) begin
`ifdef BOARD_DEBOUNCE_EN
                if (sv[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin nd[i] = sv[i]; m_run[i] = 0; end
                end else m_run[i] = 0;
`else
                nd[i] = sv[i];
`endif
            end
            ev_sw = 0; ev_btn = 0;
            for (int i = 0; i < SW_N; i++)
                if (m_event(m_deb[i], nd[i], m_edge[1:0])) ev_sw |= 32'd1 << i;
            for (int i = 0; i < BTN_N; i++)
                if (m_event(m_deb[SW_N+i], nd[SW_N+i], m_edge[9:8])) ev_btn |= 32'd1 << i;
            if (acc && we) begin
                bm = 0;
                for (int k = 0; k < 4; k++) if (sel[k]) bm |= 32'hFF << (8*k);
                wd = wdata & bm;
                case (a)
                    2: m_pend_sw  = m_pend_sw & ~wd;
                    3: m_pend_btn = m_pend_btn & ~wd;
                    4: m_led      = ((m_led & ~bm) | wd) & LED_MSK;
                    5: m_mask_sw  = ((m_mask_sw & ~bm) | wd) & SW_MSK;
                    6: m_mask_btn = ((m_mask_btn & ~bm) | wd) & BTN_MSK;
                    7: m_edge     = ((m_edge & ~bm) | wd) & 32'h0000_0303;
                    default: ;
                endcase
            end
            m_pend_sw  |= ev_sw;
            m_pend_btn |= ev_btn;
            m_deb  = nd;
            m_ack  = acc;
            m_data = acc ? rd : 32'd0;
            m_irq  = irq_n;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_led", 32'(led), m_led);
            check("cyc_irq", 32'(irq), 32'(m_irq));
            check("cyc_ack", 32'(ack), 32'(m_ack));
            check("cyc_data", rdata, m_data);
        end
    end

    // ---------------- bus helpers (called at a negedge) ----------------
    task automatic bus_op(input int a, input bit w, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] q);
        int n = 0;
        cs = 1'b1; addr = a[AB-3:0]; we = w; wdata = d; sel = s;
        do begin @(negedge clk); n++; end while (ack !== 1'b1 && n < 4);
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL bus_timeout addr %0d: ack still %b after %0d cycles, required 1", a, ack, n);
        end
        q = rdata;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        bus_op(a, 1'b1, d, s, q);
    endtask

    task automatic bus_rd(input string name, input int a, input logic [31:0] exp);
        logic [31:0] q;
        bus_op(a, 1'b0, 32'd0, 4'hF, q);
        check(name, q, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        switch = '0; btn = '0; cs = 0; we = 0; addr = '0; wdata = '0; sel = '0; rst = 1'b1;
        @(negedge clk); cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_led", 32'(led), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_data", rdata, 32'd0);
        rst = 1'b0;
        for (int a = 0; a <= 8; a++) bus_rd("reset_read", a, 32'd0);

        // Short glitch on switch[3]
        switch[3] = 1'b1; repeat (10) @(negedge clk);
        switch[3] = 1'b0; repeat (DEB_LAT + 5) @(negedge clk);
        bus_rd("glitch_sw", 0, 32'd0);
        bus_rd("glitch_pend", 2, GLITCH_PEND);

        // Held switch[3]: pending on edge DEB_LAT, interrupt one edge later
        bus_wr(2, 32'hFF, 4'hF);
        bus_wr(5, 32'h08, 4'hF);
        switch[3] = 1'b1;
        repeat (DEB_LAT) @(posedge clk);
        @(negedge clk); check("hold_irq_before", 32'(irq), 32'd0);
        @(negedge clk); check("hold_irq_after", 32'(irq), 32'd1);
        bus_rd("hold_sw", 0, 32'h08);
        bus_rd("hold_pend", 2, 32'h08);
        bus_wr(2, 32'h08, 4'hF);
        check("w1c_irq_ack_edge", 32'(irq), 32'd1);
        @(negedge clk); check("w1c_irq_drop", 32'(irq), 32'd0);
        switch[3] = 1'b0; repeat (DEB_LAT + 3) @(negedge clk);
        bus_wr(2, 32'hFF, 4'hF);

        // Button rising-only with mask
        bus_wr(6, 32'h10, 4'hF);
        bus_wr(7, 32'h0100, 4'hF);
        btn[4] = 1'b1; repeat (DEB_LAT + 3) @(negedge clk);
        bus_rd("btn_deb", 1, 32'h10);
        bus_rd("btn_pend", 3, 32'h10);
        check("btn_irq", 32'(irq), 32'd1);
        bus_wr(3, 32'h10, 4'hF);
        @(negedge clk); check("btn_irq_clr", 32'(irq), 32'd0);
        btn[4] = 1'b0; repeat (DEB_LAT + 3) @(negedge clk);
        bus_rd("btn_release_pend", 3, 32'h0);
        check("btn_release_irq", 32'(irq), 32'd0);

        // LED byte lanes
        bus_wr(4, 32'hA5A5_A5A5, 4'b0001);
        check("led_lane0", 32'(led), 32'hA5);
        bus_wr(4, 32'hFFFF_FFFF, 4'b0000);
        check("led_nolane", 32'(led), 32'hA5);
        bus_rd("led_read", 4, 32'h0000_00A5);

        // Set wins over a simultaneous W1C
        bus_wr(5, 32'hFF, 4'hF);
        bus_wr(7, 32'h0, 4'hF);
        switch[0] = 1'b1; repeat (DEB_LAT + 3) @(negedge clk);
        bus_rd("setwin_pend_pre", 2, 32'h01);
        switch[0] = 1'b0;
        repeat (DEB_LAT - 1) @(negedge clk);
        bus_wr(2, 32'h01, 4'hF);
        check("setwin_irq0", 32'(irq), 32'd1);
        @(negedge clk); check("setwin_irq1", 32'(irq), 32'd1);
        bus_rd("setwin_pend", 2, 32'h01);

        // One-cycle button pulse
        bus_wr(3, 32'hFF, 4'hF);
        btn[0] = 1'b1; @(negedge clk);
        btn[0] = 1'b0; repeat (2) @(negedge clk);
        bus_rd("pulse_btn", 1, PULSE_BTN);
        repeat (DEB_LAT + 4) @(negedge clk);
        bus_rd("pulse_pend", 3, PULSE_PEND);

        // Random traffic and pin activity, checked every cycle against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 999) == 0);
            cs    = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1);
            addr  = AB'($urandom_range(0, 11));
            wdata = $urandom;
            sel   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) begin
                int b = $urandom_range(0, NIN - 1);
                {btn, switch} = {btn, switch} ^ (NIN'(1) << b);
            end
        end
        @(negedge clk); rst = 1'b0; cs = 1'b0; we = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during an access
        cs = 1'b1; we = 1'b0; addr = '0;
        @(negedge clk); check("midrst_ack_before", 32'(ack), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_data", rdata, 32'd0);
        cs = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
